// File: rtl/ula_pkg.sv
// Shared definitions for the ULA operand sequencer: operand width, the ALU opcode and the sequencer state.
package ula_pkg;

   localparam int BITS = 8;

   typedef enum logic [1:0] {
      OP_AND = 2'b00,
      OP_OR  = 2'b01,
      OP_ADD = 2'b10,
      OP_SUB = 2'b11
   } ula_op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_DONE = 2'b10
   } seq_state_t;

   // Only ADD and SUB produce a meaningful overflow flag.
   function automatic logic op_is_arith(input logic [1:0] f);
      return f[1];
   endfunction

endpackage

// File: rtl/ula_operand_sequencer.sv
// Holds one ALU operation stable on a_o/b_o/f_o, captures the ALU result a cycle later and offers it downstream.
// Optional feature ULA_SEQ_ACC_EN: acc_i selects the previous result as operand A.
module ula_operand_sequencer
   import ula_pkg::*;
#(
   parameter int BITS = ula_pkg::BITS
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [BITS-1:0] in_a,
   input  logic [BITS-1:0] in_b,
   input  logic [1:0]      in_f,
`ifdef ULA_SEQ_ACC_EN
   input  logic            acc_i,
`endif
   output logic [BITS-1:0] a_o,
   output logic [BITS-1:0] b_o,
   output logic [1:0]      f_o,
   input  logic [BITS-1:0] res_i,
   input  logic            flag_i,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [BITS-1:0] out_res,
   output logic            out_ovf,
   output logic            ovf_sticky,
   input  logic            clr_i,
   output logic [7:0]      op_count
);

   seq_state_t      r_state;
   seq_state_t      w_next;
   logic            r_rst_done;
   logic [BITS-1:0] r_a;
   logic [BITS-1:0] r_b;
   logic [1:0]      r_f;
   logic [BITS-1:0] r_res;
   logic            r_ovf;
   logic            r_sticky;
   logic [7:0]      r_count;
   logic            w_accept;
   logic            w_capture;
   logic            w_retire;
   logic            w_ovf_cap;
   logic [BITS-1:0] w_a_sel;

   // r_rst_done keeps in_ready low through reset and for the edge that ends it.
   assign in_ready  = (r_state == ST_IDLE) && r_rst_done;
   assign out_valid = (r_state == ST_DONE);
   assign w_accept  = in_ready && in_valid;
   assign w_capture = (r_state == ST_EXEC);
   assign w_retire  = (r_state == ST_DONE) && out_ready;
   assign w_ovf_cap = flag_i && op_is_arith(r_f);

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: if (w_accept) w_next = ST_EXEC;
         ST_EXEC: w_next = ST_DONE;
         ST_DONE: if (out_ready) w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_rst_done <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_rst_done <= 1'b1;
      end
   end

`ifdef ULA_SEQ_ACC_EN
   logic [BITS-1:0] r_last;

   always_ff @(posedge clk) begin
      if (reset)          r_last <= '0;
      else if (w_capture) r_last <= res_i;
   end

   assign w_a_sel = acc_i ? r_last : in_a;
`else
   assign w_a_sel = in_a;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_a <= '0;
         r_b <= '0;
         r_f <= 2'b00;
      end else if (w_accept) begin
         r_a <= w_a_sel;
         r_b <= in_b;
         r_f <= in_f;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_res <= '0;
         r_ovf <= 1'b0;
      end else if (w_capture) begin
         r_res <= res_i;
         r_ovf <= w_ovf_cap;
      end
   end

   // A fresh overflow capture takes priority over a simultaneous clear.
   always_ff @(posedge clk) begin
      if (reset)                        r_sticky <= 1'b0;
      else if (w_capture && w_ovf_cap)  r_sticky <= 1'b1;
      else if (clr_i)                   r_sticky <= 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset)         r_count <= 8'd0;
      else if (w_retire) r_count <= r_count + 8'd1;
   end

   assign a_o        = r_a;
   assign b_o        = r_b;
   assign f_o        = r_f;
   assign out_res    = r_res;
   assign out_ovf    = r_ovf;
   assign ovf_sticky = r_sticky;
   assign op_count   = r_count;

endmodule
